// File: rtl/sign_mag_accum.sv
// Sequential sign-magnitude accumulator: reduces a run of `len` operands to a
// saturated total, delivered with a sticky overflow flag over valid/ready.
module sign_mag_accum #(
    parameter int N     = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic             out_ovf,
    input  logic             out_ready,
    output logic             busy
);

    localparam int M = N - 1;
    localparam logic [M-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic [N:0]       add_res;

    // Returns {overflow, result}; a negative zero on either input is read as +0,
    // and the result never carries a negative zero.
    function automatic logic [N:0] sm_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic           sa, sb;
        logic [M-1:0]   ma, mb;
        logic [M:0]     sum;
        ma  = a[M-1:0];
        mb  = b[M-1:0];
        sa  = a[N-1] & (ma != '0);
        sb  = b[N-1] & (mb != '0);
        sum = {1'b0, ma} + {1'b0, mb};
        if (sa == sb) begin
            if (sum > {1'b0, MAX}) sm_add = {1'b1, sa, MAX};
            else                   sm_add = {1'b0, sa, sum[M-1:0]};
        end else if (ma > mb) begin
            sm_add = {1'b0, sa, ma - mb};
        end else if (mb > ma) begin
            sm_add = {1'b0, sb, mb - ma};
        end else begin
            sm_add = '0;
        end
    endfunction

    assign add_res = sm_add(acc_q, in_data);

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = add_res[N-1:0];
                    ovf_d = ovf_q | add_res[N];
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_valid ? acc_q : '0;
    assign out_ovf   = out_valid & ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sign_mag_accum.sv
// Bench for sign_mag_accum: table-driven runs, handshake/reset corner cases and
// an exhaustive two-operand sweep against an integer reference model.
module tb_sign_mag_accum;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ovf;
    logic       out_ready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]      len;
        logic [3:0][3:0] ops;
        logic [3:0]      exp_data;
        logic            exp_ovf;
    } vec_t;

    typedef struct packed {
        logic [3:0] data;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    sign_mag_accum #(.N(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: signed integer sum clamped to +/-7, re-encoded as sign-magnitude.
    function automatic exp_t model_add(input logic [3:0] a, input logic [3:0] b, input logic ovf_in);
        int   va, vb, s;
        exp_t r;
        va = a[3] ? -int'(a[2:0]) : int'(a[2:0]);
        vb = b[3] ? -int'(b[2:0]) : int'(b[2:0]);
        s  = va + vb;
        r.ovf = ovf_in;
        if (s > 7)  begin s = 7;  r.ovf = 1'b1; end
        if (s < -7) begin s = -7; r.ovf = 1'b1; end
        r.data = (s < 0) ? {1'b1, 3'(-s)} : {1'b0, 3'(s)};
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] l, input logic [3:0] o0, input logic [3:0] o1,
                                input logic [3:0] o2, input logic [3:0] o3,
                                input logic [3:0] d, input logic ovf);
        vec_t v;
        v.len = l;
        v.ops = {o3, o2, o1, o0};
        v.exp_data = d;
        v.exp_ovf = ovf;
        return v;
    endfunction

    task automatic start_run(input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_op(input logic [3:0] d);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready timeout: got 0 expected 1");
        end
        @(negedge clk);
    endtask

    task automatic collect(input string tag);
        int   waited = 0;
        exp_t e;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL %s out_valid timeout: got 0 expected 1", tag);
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty: got result %0h expected none", tag, out_data);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " data"}, 32'(out_data), 32'(e.data));
        check({tag, " ovf"}, 32'(out_ovf), 32'(e.ovf));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " back to idle"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        exp_t e;
        e.data = v.exp_data;
        e.ovf  = v.exp_ovf;
        sb_q.push_back(e);
        start_run(v.len);
        for (int i = 0; i < int'(v.len); i++) send_op(v.ops[i]);
        in_valid = 1'b0;
        check({tag, " latency"}, 32'(out_valid), 32'd1);
        collect(tag);
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        vecs[0] = mk(4'd3, 4'b0011, 4'b1101, 4'b0100, 4'b0000, 4'b0010, 1'b0);
        vecs[1] = mk(4'd2, 4'b0101, 4'b0110, 4'b0000, 4'b0000, 4'b0111, 1'b1);
        vecs[2] = mk(4'd3, 4'b1101, 4'b1110, 4'b0111, 4'b0000, 4'b0000, 1'b1);
        vecs[3] = mk(4'd1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        vecs[4] = mk(4'd2, 4'b0101, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        vecs[5] = mk(4'd0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        vecs[6] = mk(4'd4, 4'b1111, 4'b1111, 4'b0011, 4'b0001, 4'b1011, 1'b1);
        vecs[7] = mk(4'd4, 4'b0001, 4'b0010, 4'b1011, 4'b0100, 4'b0100, 1'b0);
        vecs[8] = mk(4'd2, 4'b1010, 4'b1001, 4'b0000, 4'b0000, 4'b1011, 1'b0);
        vecs[9] = mk(4'd2, 4'b1000, 4'b1011, 4'b0000, 4'b0000, 4'b1011, 1'b0);

        #1;
        check("reset outputs", {27'd0, in_ready, out_valid, out_data, out_ovf, busy}, 32'd0);
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle after reset", {30'd0, busy, out_valid}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Input stall mid-run: in_ready stays high and nothing is consumed.
        sb_q.push_back('{data: 4'b0100, ovf: 1'b0});
        start_run(4'd3);
        send_op(4'b0011);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall in_ready", 32'(in_ready), 32'd1);
            check("stall no out_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        send_op(4'b0010);
        send_op(4'b1001);
        in_valid = 1'b0;
        check("stall latency", 32'(out_valid), 32'd1);
        collect("stall");

        // start pulsed during ACCUM must neither restart nor change the length.
        sb_q.push_back('{data: 4'b0011, ovf: 1'b0});
        start_run(4'd2);
        send_op(4'b0001);
        in_valid = 1'b0;
        start = 1'b1;
        len   = 4'd5;
        @(negedge clk);
        start = 1'b0;
        check("start ignored in_ready", 32'(in_ready), 32'd1);
        send_op(4'b0010);
        in_valid = 1'b0;
        check("start ignored latency", 32'(out_valid), 32'd1);
        collect("start ignored");

        // Output back-pressure: result held stable while out_ready is low.
        sb_q.push_back('{data: 4'b0110, ovf: 1'b0});
        start_run(4'd1);
        send_op(4'b0110);
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold out_data", 32'(out_data), 32'h6);
            @(negedge clk);
        end
        collect("hold");

        // Reset between the 2nd and 3rd operand of a 4-operand run.
        start_run(4'd4);
        send_op(4'b0011);
        send_op(4'b0010);
        in_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("mid-run reset outputs", {27'd0, in_ready, out_valid, out_data, out_ovf, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("after reset no out_valid", {30'd0, out_valid, busy}, 32'd0);
            @(negedge clk);
        end
        run_vec(mk(4'd2, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b0), "post reset");

        // Exhaustive two-operand sweep against the integer model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e = model_add(4'd0, 4'(a), 1'b0);
                e = model_add(e.data, 4'(b), e.ovf);
                sb_q.push_back(e);
                start_run(4'd2);
                send_op(4'(a));
                send_op(4'(b));
                in_valid = 1'b0;
                check($sformatf("sweep %0h+%0h latency", a, b), 32'(out_valid), 32'd1);
                collect($sformatf("sweep %0h+%0h", a, b));
            end
        end

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
